// File: rtl/countdown_ctrl_if.sv
// Signal bundle between the countdown controller, the system sequencer
// and the 4-bit loadable down counter.
//
// Handshake: start is a request level that is accepted at a rising edge only
// while the controller is IDLE (busy=0) and abort=0. There is no separate
// ready; busy=0 is the ready indication. load_val must be valid at that edge.
// Once accepted, busy stays high until the edge after the done pulse, or
// until an abort.
interface countdown_ctrl_if #(
  parameter int WIDTH = 4
);
  // Sequencer side
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dec_cnt;
  // Counter side
  logic             cnt_zero;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_latch;
  logic             cnt_dec;
  // Debug view of the controller FSM (0=IDLE 1=LOAD 2=RUN 3=DONE)
  logic [1:0]       dbg_state;

  // Controller side
  modport master (
    input  start, load_val, pause, abort, cnt_zero,
    output busy, done, dec_cnt, cnt_in, cnt_latch, cnt_dec, dbg_state
  );

  // Environment side (sequencer plus counter)
  modport slave (
    output start, load_val, pause, abort, cnt_zero,
    input  busy, done, dec_cnt, cnt_in, cnt_latch, cnt_dec, dbg_state
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Countdown controller: loads an external down counter, then issues paced
// decrement pulses until the counter reports zero, and ends with a one-cycle
// done pulse. Supports pause (freezes pacing) and abort (back to IDLE).
module countdown_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  countdown_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last prescaler value of a pacing period; a dec is issued there.
  localparam logic [7:0] LP_LAST = 8'(PRESCALE - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_presc;
  logic [WIDTH-1:0] r_cnt_in;
  logic [WIDTH-1:0] r_dec_cnt;
  logic             w_start_ok;
  logic             w_latch;
  logic             w_dec;
  logic             w_busy;
  logic             w_done;
  logic             w_presc_step;

  // A start is taken only from IDLE and never in the same edge as an abort.
  assign w_start_ok = (r_state == S_IDLE) && bus.start && !bus.abort;

  // Prescaler advances only in live RUN cycles: not paused, not finishing,
  // not aborting.
  assign w_presc_step = (r_state == S_RUN) && !bus.cnt_zero && !bus.pause && !bus.abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and state-decoded outputs; abort outranks everything.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_dec        = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_start_ok) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        // Latch asserts for this whole cycle even if abort is raised; the
        // counter keeps the loaded value in that case.
        w_latch = 1'b1;
        if (bus.abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        // cnt_zero depends only on the counter register, so feeding it back
        // into dec combinationally does not form a loop.
        w_dec = (r_presc == LP_LAST) && !bus.pause && !bus.cnt_zero && !bus.abort;
        if (bus.abort) begin
          w_next_state = S_IDLE;
        end else if (bus.cnt_zero) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Load value capture: cnt_in holds until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_in <= '0;
    end else if (w_start_ok) begin
      r_cnt_in <= bus.load_val;
    end
  end

  // Prescaler: cleared on start, wraps at PRESCALE-1, holds while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 8'd0;
    end else if (w_start_ok) begin
      r_presc <= 8'd0;
    end else if (w_presc_step) begin
      if (r_presc == LP_LAST) begin
        r_presc <= 8'd0;
      end else begin
        r_presc <= r_presc + 8'd1;
      end
    end
  end

  // Decrement tally for the current or most recent run; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_cnt <= '0;
    end else if (w_start_ok) begin
      r_dec_cnt <= '0;
    end else if (w_dec && (r_dec_cnt != {WIDTH{1'b1}})) begin
      r_dec_cnt <= r_dec_cnt + 1'b1;
    end
  end

  assign bus.cnt_in    = r_cnt_in;
  assign bus.cnt_latch = w_latch;
  assign bus.cnt_dec   = w_dec;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.dec_cnt   = r_dec_cnt;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: three controllers (PRESCALE 1, 3, 255), each
// paired with a behavioural 4-bit down counter. Inputs change on the falling
// edge; outputs are sampled 1 time unit later.
module tb_countdown_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       start_v [3];
  logic [3:0] load_val;
  logic       pause;
  logic       abort;

  int n_vec;
  int n_err;

  countdown_ctrl_if #(.WIDTH(4)) if_p1 ();
  countdown_ctrl_if #(.WIDTH(4)) if_p3 ();
  countdown_ctrl_if #(.WIDTH(4)) if_p255 ();

  countdown_ctrl #(.WIDTH(4), .PRESCALE(1))   u_p1   (.clk(clk), .rst_n(rst_n), .bus(if_p1));
  countdown_ctrl #(.WIDTH(4), .PRESCALE(3))   u_p3   (.clk(clk), .rst_n(rst_n), .bus(if_p3));
  countdown_ctrl #(.WIDTH(4), .PRESCALE(255)) u_p255 (.clk(clk), .rst_n(rst_n), .bus(if_p255));

  assign if_p1.start      = start_v[0];
  assign if_p3.start      = start_v[1];
  assign if_p255.start    = start_v[2];
  assign if_p1.load_val   = load_val;
  assign if_p3.load_val   = load_val;
  assign if_p255.load_val = load_val;
  assign if_p1.pause      = pause;
  assign if_p3.pause      = pause;
  assign if_p255.pause    = pause;
  assign if_p1.abort      = abort;
  assign if_p3.abort      = abort;
  assign if_p255.abort    = abort;

  // ---------------- behavioural down counters ----------------
  logic [3:0] cnt0, cnt1, cnt2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt0 <= 4'd0;
    else if (if_p1.cnt_latch) cnt0 <= if_p1.cnt_in;
    else if (if_p1.cnt_dec) cnt0 <= cnt0 - 4'd1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt1 <= 4'd0;
    else if (if_p3.cnt_latch) cnt1 <= if_p3.cnt_in;
    else if (if_p3.cnt_dec) cnt1 <= cnt1 - 4'd1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt2 <= 4'd0;
    else if (if_p255.cnt_latch) cnt2 <= if_p255.cnt_in;
    else if (if_p255.cnt_dec) cnt2 <= cnt2 - 4'd1;
  end

  assign if_p1.cnt_zero   = (cnt0 == 4'd0);
  assign if_p3.cnt_zero   = (cnt1 == 4'd0);
  assign if_p255.cnt_zero = (cnt2 == 4'd0);

  // ---------------- observation ----------------
  typedef struct packed {
    logic       lat;
    logic       dec;
    logic       busy;
    logic       done;
    logic       zero;
    logic [3:0] cin;
    logic [3:0] dcnt;
    logic [3:0] cnt;
    logic [1:0] st;
  } obs_t;

  function automatic obs_t get_obs(input int inst);
    obs_t o;
    o = '0;
    case (inst)
      0: begin
        o.lat = if_p1.cnt_latch; o.dec = if_p1.cnt_dec; o.busy = if_p1.busy;
        o.done = if_p1.done; o.zero = if_p1.cnt_zero; o.cin = if_p1.cnt_in;
        o.dcnt = if_p1.dec_cnt; o.cnt = cnt0; o.st = if_p1.dbg_state;
      end
      1: begin
        o.lat = if_p3.cnt_latch; o.dec = if_p3.cnt_dec; o.busy = if_p3.busy;
        o.done = if_p3.done; o.zero = if_p3.cnt_zero; o.cin = if_p3.cnt_in;
        o.dcnt = if_p3.dec_cnt; o.cnt = cnt1; o.st = if_p3.dbg_state;
      end
      default: begin
        o.lat = if_p255.cnt_latch; o.dec = if_p255.cnt_dec; o.busy = if_p255.busy;
        o.done = if_p255.done; o.zero = if_p255.cnt_zero; o.cin = if_p255.cnt_in;
        o.dcnt = if_p255.dec_cnt; o.cnt = cnt2; o.st = if_p255.dbg_state;
      end
    endcase
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  // Raise start with a load value; it is taken at the next rising edge (E0).
  task automatic do_start(input int inst, input logic [3:0] val);
    @(negedge clk);
    load_val      = val;
    start_v[inst] = 1'b1;
  endtask

  // Step ncyc cycles; cycle k is the cycle after edge Ek. Inputs for cycle k
  // come from bit k of the masks; bit k of each trace is the sampled output.
  task automatic capture(input int inst, input int ncyc,
                         input logic [63:0] pause_m, input logic [63:0] abort_m,
                         input logic [63:0] start_m, input logic [3:0] lv_after,
                         output logic [63:0] lat_t, output logic [63:0] dec_t,
                         output logic [63:0] done_t, output logic [63:0] busy_t);
    obs_t o;
    lat_t = '0; dec_t = '0; done_t = '0; busy_t = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) load_val = lv_after;
      start_v[inst] = start_m[k];
      pause         = pause_m[k];
      abort         = abort_m[k];
      #1;
      o = get_obs(inst);
      lat_t[k]  = o.lat;
      dec_t[k]  = o.dec;
      done_t[k] = o.done;
      busy_t[k] = o.busy;
    end
    start_v[inst] = 1'b0;
    pause         = 1'b0;
    abort         = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t o;
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      n_vec++;
      if ({o.lat, o.dec, o.busy, o.done, o.cin, o.dcnt, o.st} !== 15'd0) begin
        n_err++;
        $display("FAIL reset_outputs inst=%0d got lat=%b dec=%b busy=%b done=%b cin=%h dcnt=%h st=%0d expected all 0",
                 i, o.lat, o.dec, o.busy, o.done, o.cin, o.dcnt, o.st);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] lat_t, dec_t, done_t, busy_t;
    obs_t o;
    do_start(0, 4'd5);
    capture(0, 10, 64'h0, 64'h0, 64'h0, 4'd5, lat_t, dec_t, done_t, busy_t);
    o = get_obs(0);
    n_vec++; if (lat_t !== 64'h1) begin n_err++; $display("FAIL basic_latch got=%h exp=%h", lat_t, 64'h1); end
    n_vec++; if (dec_t !== 64'h3E) begin n_err++; $display("FAIL basic_dec got=%h exp=%h", dec_t, 64'h3E); end
    n_vec++; if (done_t !== 64'h80) begin n_err++; $display("FAIL basic_done got=%h exp=%h", done_t, 64'h80); end
    n_vec++; if (busy_t !== 64'hFF) begin n_err++; $display("FAIL basic_busy got=%h exp=%h", busy_t, 64'hFF); end
    n_vec++; if (o.dcnt !== 4'd5) begin n_err++; $display("FAIL basic_dec_cnt got=%0d exp=5", o.dcnt); end
    n_vec++; if (o.cnt !== 4'd0) begin n_err++; $display("FAIL basic_counter got=%0d exp=0", o.cnt); end
    n_vec++; if (o.cin !== 4'd5) begin n_err++; $display("FAIL basic_cnt_in got=%0d exp=5", o.cin); end
  endtask

  task automatic test_zero_load();
    logic [63:0] lat_t, dec_t, done_t, busy_t;
    obs_t o;
    do_start(0, 4'd0);
    capture(0, 5, 64'h0, 64'h0, 64'h0, 4'd0, lat_t, dec_t, done_t, busy_t);
    o = get_obs(0);
    n_vec++; if (lat_t !== 64'h1) begin n_err++; $display("FAIL zero_latch got=%h exp=%h", lat_t, 64'h1); end
    n_vec++; if (dec_t !== 64'h0) begin n_err++; $display("FAIL zero_dec got=%h exp=%h", dec_t, 64'h0); end
    n_vec++; if (done_t !== 64'h4) begin n_err++; $display("FAIL zero_done got=%h exp=%h", done_t, 64'h4); end
    n_vec++; if (busy_t !== 64'h7) begin n_err++; $display("FAIL zero_busy got=%h exp=%h", busy_t, 64'h7); end
    n_vec++; if (o.dcnt !== 4'd0) begin n_err++; $display("FAIL zero_dec_cnt got=%0d exp=0", o.dcnt); end
  endtask

  task automatic test_prescale_pause();
    logic [63:0] lat_t, dec_t, done_t, busy_t;
    obs_t o;
    // P=3, N=2: dec in RUN cycles 2 and 5, DONE entered at E8
    do_start(1, 4'd2);
    capture(1, 11, 64'h0, 64'h0, 64'h0, 4'd2, lat_t, dec_t, done_t, busy_t);
    o = get_obs(1);
    n_vec++; if (lat_t !== 64'h1) begin n_err++; $display("FAIL presc_latch got=%h exp=%h", lat_t, 64'h1); end
    n_vec++; if (dec_t !== 64'h48) begin n_err++; $display("FAIL presc_dec got=%h exp=%h", dec_t, 64'h48); end
    n_vec++; if (done_t !== 64'h100) begin n_err++; $display("FAIL presc_done got=%h exp=%h", done_t, 64'h100); end
    n_vec++; if (busy_t !== 64'h1FF) begin n_err++; $display("FAIL presc_busy got=%h exp=%h", busy_t, 64'h1FF); end
    n_vec++; if (o.dcnt !== 4'd2) begin n_err++; $display("FAIL presc_dec_cnt got=%0d exp=2", o.dcnt); end
    // Same run with pause over RUN cycles 3..6: second dec moves to RUN 9, DONE at E12
    do_start(1, 4'd2);
    capture(1, 15, 64'hF0, 64'h0, 64'h0, 4'd2, lat_t, dec_t, done_t, busy_t);
    o = get_obs(1);
    n_vec++; if (dec_t !== 64'h408) begin n_err++; $display("FAIL pause_dec got=%h exp=%h", dec_t, 64'h408); end
    n_vec++; if (done_t !== 64'h1000) begin n_err++; $display("FAIL pause_done got=%h exp=%h", done_t, 64'h1000); end
    n_vec++; if (busy_t !== 64'h1FFF) begin n_err++; $display("FAIL pause_busy got=%h exp=%h", busy_t, 64'h1FFF); end
    n_vec++; if (o.dcnt !== 4'd2) begin n_err++; $display("FAIL pause_dec_cnt got=%0d exp=2", o.dcnt); end
  endtask

  task automatic test_abort();
    logic [63:0] lat_t, dec_t, done_t, busy_t;
    obs_t o;
    // abort in RUN cycle 3 (cycle 4 after E0)
    do_start(0, 4'd9);
    capture(0, 8, 64'h0, 64'h10, 64'h0, 4'd9, lat_t, dec_t, done_t, busy_t);
    o = get_obs(0);
    n_vec++; if (dec_t !== 64'hE) begin n_err++; $display("FAIL abort_dec got=%h exp=%h", dec_t, 64'hE); end
    n_vec++; if (done_t !== 64'h0) begin n_err++; $display("FAIL abort_done got=%h exp=%h", done_t, 64'h0); end
    n_vec++; if (busy_t !== 64'h1F) begin n_err++; $display("FAIL abort_busy got=%h exp=%h", busy_t, 64'h1F); end
    n_vec++; if (o.dcnt !== 4'd3) begin n_err++; $display("FAIL abort_dec_cnt got=%0d exp=3", o.dcnt); end
    n_vec++; if (o.cnt !== 4'd6) begin n_err++; $display("FAIL abort_counter got=%0d exp=6", o.cnt); end
    n_vec++; if (o.zero !== 1'b0) begin n_err++; $display("FAIL abort_zero got=%b exp=0", o.zero); end
    n_vec++; if (o.st !== 2'd0) begin n_err++; $display("FAIL abort_state got=%0d exp=0", o.st); end
  endtask

  task automatic test_ignored_start_reset();
    logic [63:0] lat_t, dec_t, done_t, busy_t;
    obs_t o;
    // load_val changes to 2 after capture and start is re-pulsed in RUN cycle 1
    do_start(0, 4'd9);
    capture(0, 4, 64'h0, 64'h0, 64'h4, 4'd2, lat_t, dec_t, done_t, busy_t);
    o = get_obs(0);
    n_vec++; if (lat_t !== 64'h1) begin n_err++; $display("FAIL ign_latch got=%h exp=%h", lat_t, 64'h1); end
    n_vec++; if (dec_t !== 64'hE) begin n_err++; $display("FAIL ign_dec got=%h exp=%h", dec_t, 64'hE); end
    n_vec++; if (o.cin !== 4'd9) begin n_err++; $display("FAIL ign_cnt_in got=%0d exp=9", o.cin); end
    n_vec++; if (o.cnt !== 4'd7) begin n_err++; $display("FAIL ign_counter got=%0d exp=7", o.cnt); end
    // asynchronous reset mid-run
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    o = get_obs(0);
    n_vec++;
    if ({o.lat, o.dec, o.busy, o.done, o.cin, o.dcnt, o.st} !== 15'd0) begin
      n_err++;
      $display("FAIL midrun_reset got lat=%b dec=%b busy=%b done=%b cin=%h dcnt=%h st=%0d expected all 0",
               o.lat, o.dec, o.busy, o.done, o.cin, o.dcnt, o.st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // full-range run after reset: DONE at E17
    do_start(0, 4'd15);
    capture(0, 20, 64'h0, 64'h0, 64'h0, 4'd15, lat_t, dec_t, done_t, busy_t);
    o = get_obs(0);
    n_vec++; if (lat_t !== 64'h1) begin n_err++; $display("FAIL r15_latch got=%h exp=%h", lat_t, 64'h1); end
    n_vec++; if (dec_t !== 64'hFFFE) begin n_err++; $display("FAIL r15_dec got=%h exp=%h", dec_t, 64'hFFFE); end
    n_vec++; if (done_t !== 64'h20000) begin n_err++; $display("FAIL r15_done got=%h exp=%h", done_t, 64'h20000); end
    n_vec++; if (busy_t !== 64'h3FFFF) begin n_err++; $display("FAIL r15_busy got=%h exp=%h", busy_t, 64'h3FFFF); end
    n_vec++; if (o.dcnt !== 4'd15) begin n_err++; $display("FAIL r15_dec_cnt got=%0d exp=15", o.dcnt); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int   first_dec;
    int   last_dec;
    int   ndec;
    int   gap_bad;
    int   done_cyc;
    logic [3:0] dcnt_at_done;
    first_dec = -1; last_dec = -1; ndec = 0; gap_bad = 0; done_cyc = -1;
    dcnt_at_done = 4'd0;
    // P=255, N=15: decs at cycles 255 + 255*j, DONE at E3827
    do_start(2, 4'd15);
    for (int k = 0; k < 5000 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (k == 0) start_v[2] = 1'b0;
      #1;
      o = get_obs(2);
      if (o.dec) begin
        if (ndec == 0) first_dec = k;
        else if (k - last_dec != 255) gap_bad++;
        last_dec = k;
        ndec++;
      end
      if (o.done) begin
        done_cyc = k;
        dcnt_at_done = o.dcnt;
      end
    end
    n_vec++; if (done_cyc != 3827) begin n_err++; $display("FAIL max_done_cycle got=%0d exp=3827", done_cyc); end
    n_vec++; if (ndec != 15) begin n_err++; $display("FAIL max_dec_count got=%0d exp=15", ndec); end
    n_vec++; if (first_dec != 255) begin n_err++; $display("FAIL max_first_dec got=%0d exp=255", first_dec); end
    n_vec++; if (gap_bad != 0) begin n_err++; $display("FAIL max_dec_spacing got=%0d bad gaps exp=0", gap_bad); end
    n_vec++; if (dcnt_at_done !== 4'd15) begin n_err++; $display("FAIL max_dec_cnt got=%0d exp=15", dcnt_at_done); end
    // start raised while done is high (load 3): must be ignored
    start_v[2] = 1'b1;
    load_val   = 4'd3;
    // first IDLE cycle: keep start high with load 1; it is taken at the next edge
    @(negedge clk);
    load_val = 4'd1;
    #1;
    o = get_obs(2);
    n_vec++; if ({o.busy, o.lat} !== 2'b00) begin n_err++; $display("FAIL b2b_idle got busy=%b lat=%b exp busy=0 lat=0", o.busy, o.lat); end
    // LOAD cycle with abort raised: latch still asserts
    @(negedge clk);
    start_v[2] = 1'b0;
    abort      = 1'b1;
    #1;
    o = get_obs(2);
    n_vec++; if (o.lat !== 1'b1) begin n_err++; $display("FAIL b2b_latch got=%b exp=1", o.lat); end
    n_vec++; if (o.cin !== 4'd1) begin n_err++; $display("FAIL b2b_cnt_in got=%0d exp=1", o.cin); end
    @(negedge clk);
    abort = 1'b0;
    #1;
    o = get_obs(2);
    n_vec++; if ({o.busy, o.done} !== 2'b00) begin n_err++; $display("FAIL load_abort_idle got busy=%b done=%b exp 0 0", o.busy, o.done); end
    n_vec++; if (o.cnt !== 4'd1) begin n_err++; $display("FAIL load_abort_counter got=%0d exp=1", o.cnt); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    start_v[2] = 1'b0;
    load_val   = 4'd0;
    pause      = 1'b0;
    abort      = 1'b0;
    test_reset();
    test_basic();
    test_zero_load();
    test_prescale_pause();
    test_abort();
    test_ignored_start_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Controller for the 4-bit loadable down counter. Drives the counter's load value, `Latch` and `dec` inputs, and watches its combinational `zero` output.
- Takes a start request with a load value, loads the counter, then issues paced decrement pulses until `zero` is seen. Finishes with a one-cycle done pulse.
- Sits between the system sequencer (start/abort/pause) and the down counter.

Parameters:
- WIDTH, 4, width of the load value and of the counter interface.
- PRESCALE, 1, number of RUN cycles per decrement pulse; legal values are 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a countdown; sampled only in IDLE.
- load_val  input  WIDTH  initial count; captured on an accepted start.
- pause  input  1  freezes the prescaler and suppresses `dec` while high.
- abort  input  1  terminates any operation; returns to IDLE.
- cnt_zero  input  1  the counter's `zero` output; combinational from the counter register.
- cnt_in  output  WIDTH  drives the counter `IN` port; registered.
- cnt_latch  output  1  drives the counter `Latch` port.
- cnt_dec  output  1  drives the counter `dec` port.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when the countdown completes.
- dec_cnt  output  WIDTH  number of `dec` pulses issued in the current or most recent run.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - cnt_in, cnt_latch, cnt_dec, busy, done and dec_cnt all read 0.
  - The prescaler clears to 0.
  - Reset mid-operation abandons the run with no done pulse.
- States are IDLE, LOAD, RUN and DONE.
- IDLE:
  - If start=1 and abort=0 at an edge: cnt_in <= load_val, dec_cnt <= 0, prescaler <= 0, go to LOAD.
  - Otherwise hold; start is ignored in all other states.
- LOAD:
  - cnt_latch=1 for exactly this cycle; it is decoded from state.
  - The counter loads at the next edge; go to RUN.
- RUN:
  - cnt_zero is valid from the first RUN cycle.
  - If cnt_zero=1 at an edge, go to DONE.
  - Otherwise, if pause=0, the prescaler increments and wraps from PRESCALE-1 to 0. If pause=1, the prescaler holds.
- cnt_dec:
  - cnt_dec = (state==RUN) && (prescaler==PRESCALE-1) && !pause && !cnt_zero && !abort.
  - It is combinational, and there is no loop because cnt_zero depends only on the counter register.
  - dec_cnt increments at every edge where cnt_dec=1.
  - dec_cnt saturates at all-ones and never wraps.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - busy = (state != IDLE), so busy includes LOAD, RUN and DONE.
- Abort:
  - abort=1 at an edge in LOAD, RUN or DONE goes to IDLE with no done pulse.
  - abort has priority over the cnt_zero transition and over start.
  - If abort=1 in the LOAD cycle, cnt_latch still asserts in that cycle; the counter keeps the new value and the controller returns to IDLE.
- Latency, with start accepted at edge E0, N = load_val and P = PRESCALE:
  - LOAD occupies the cycle after E0.
  - RUN is entered at E1.
  - Decrements occur in RUN cycles k*P-1, for k = 1..N.
  - cnt_zero is seen in RUN cycle N*P.
  - DONE is entered at edge E(N*P+2), and done is high for the following cycle.
  - Pause cycles in RUN add 1 cycle each.
- Boundary cases:
  - load_val=0: one RUN cycle, no dec, DONE entered at E2, dec_cnt=0.
  - Pause while cnt_zero=1: the RUN→DONE transition still occurs.
  - load_val changing after capture has no effect; cnt_in holds until the next accepted start.
  - done and start in the same cycle: start is ignored, because the state is DONE, not IDLE.

Test Plan:
- Basic run: P=1, load_val=5, start pulse at E0 → cnt_latch high 1 cycle; cnt_dec high 5 consecutive cycles; done high in the cycle after E7; dec_cnt=5; busy falls after done.
- Zero load: load_val=0 → no cnt_dec; done in the cycle after E2; dec_cnt=0.
- Prescale and pause: P=3, load_val=2 → dec in RUN cycles 2 and 5; done after E8. Repeat with pause held for 4 cycles in mid-run → done after E12, with no dec during the pause.
- Abort: P=1, load_val=9, abort in RUN cycle 3 → IDLE at the next edge, no done, cnt_dec low in the abort cycle, dec_cnt=3; the counter holds 6 and its zero output stays 0.
- Ignored start and reset: start pulsed during RUN → no reload. Then rst_n=0 mid-run → all outputs 0 immediately; after release, start with load_val=15 and P=1 → done after E17, dec_cnt=15.
- Max value and back-to-back: load_val=15, P=255 → 15 dec pulses spaced 255 cycles apart. Then a start in the first IDLE cycle after done is accepted.
